// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared width default and direction encoding for up_down_count
package count_pkg;

   localparam int COUNT_WIDTH_DEFAULT = 16;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/count_step.sv
// rtl/count_step.sv - combinational next-value and wrap-detect for the up/down counter
module count_step
   import count_pkg::*;
#(
   parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] i_value,
   input  dir_e             i_dir,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

   always_comb begin
      o_next = i_value;
      o_wrap = 1'b0;
      if (i_dir == DIR_DOWN) begin
         o_next = i_value - 1'b1;
         o_wrap = (i_value == '0);
      end else begin
         o_next = i_value + 1'b1;
         o_wrap = (&i_value);
      end
   end

endmodule

// File: rtl/up_down_count.sv
// rtl/up_down_count.sv - free-running modulo-2^WIDTH up/down counter; COUNT_WRAP_FLAG_EN adds the wrap pulse
module up_down_count
   import count_pkg::*;
#(
   parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_down,
`ifdef COUNT_WRAP_FLAG_EN
   output logic             wrap,
`endif
   output logic [WIDTH-1:0] count_out,
   output logic             up_count
);

   logic [WIDTH-1:0] r_count;
   logic             r_up_count;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap_det;
   dir_e             w_dir;

   assign w_dir = dir_e'(up_down);

   count_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_value (r_count),
      .i_dir   (w_dir),
      .o_next  (w_next),
      .o_wrap  (w_wrap_det)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count    <= '0;
         r_up_count <= 1'b0;
      end else begin
         r_count    <= w_next;
         r_up_count <= up_down;
      end
   end

   assign count_out = r_count;
   assign up_count  = r_up_count;

`ifdef COUNT_WRAP_FLAG_EN
   logic r_wrap;

   // Registered alongside the count so the pulse lines up with the wrapped value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_det;
      end
   end

   assign wrap = r_wrap;
`else
   logic w_unused_wrap;
   assign w_unused_wrap = w_wrap_det;
`endif

endmodule

// File: tb/tb_up_down_count.sv
// tb/tb_up_down_count.sv - self-checking bench for up_down_count (table, corner sequences, random vs model)
module tb_up_down_count;

   logic        clk;
   logic        rst;
   logic        up_down;
   logic [15:0] count_out;
   logic        up_count;
`ifdef COUNT_WRAP_FLAG_EN
   logic        wrap;
`endif

   int n_checks;
   int n_fail;

   int m_cnt;
   bit m_up;
   bit m_wrap;

   typedef struct {
      bit r;
      bit d;
      int c;
      bit u;
      bit w;
   } vec_t;

   vec_t vecs[$];

   up_down_count #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .up_down   (up_down),
`ifdef COUNT_WRAP_FLAG_EN
      .wrap      (wrap),
`endif
      .count_out (count_out),
      .up_count  (up_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(bit r, bit d, int c, bit u, bit w);
      vec_t v;
      v.r = r; v.d = d; v.c = c; v.u = u; v.w = w;
      vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, wrap means the unbounded result left 0..65535.
   task automatic tick(input bit r, input bit d);
      int nxt;
      @(negedge clk);
      rst     = r;
      up_down = d;
      @(posedge clk);
      #1;
      if (!r) begin
         m_cnt = 0; m_up = 0; m_wrap = 0;
      end else begin
         nxt    = m_cnt + (d ? -1 : 1);
         m_wrap = (nxt < 0) || (nxt > 65535);
         m_cnt  = (nxt + 65536) % 65536;
         m_up   = d;
      end
   endtask

   task automatic check_model(input string nm);
      check({nm, ".count"}, int'(count_out), m_cnt);
      check({nm, ".up"}, int'(up_count), int'(m_up));
`ifdef COUNT_WRAP_FLAG_EN
      check({nm, ".wrap"}, int'(wrap), int'(m_wrap));
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      up_down  = 1'b0;

      add(0, 0, 0, 0, 0);
      for (int i = 1; i <= 12; i++) add(1, 0, i, 0, 0);
      for (int i = 1; i <= 8; i++)  add(1, 1, 12 - i, 1, 0);
      add(1, 1, 3, 1, 0);
      add(1, 1, 2, 1, 0);
      add(1, 1, 1, 1, 0);
      add(1, 1, 0, 1, 0);
      add(1, 1, 16'hFFFF, 1, 1);
      add(1, 1, 16'hFFFE, 1, 0);
      add(1, 0, 16'hFFFF, 0, 0);
      add(1, 0, 0, 0, 1);
      add(1, 0, 1, 0, 0);

      foreach (vecs[i]) begin
         tick(vecs[i].r, vecs[i].d);
         check($sformatf("vec%0d.count", i), int'(count_out), vecs[i].c);
         check($sformatf("vec%0d.up", i), int'(up_count), int'(vecs[i].u));
`ifdef COUNT_WRAP_FLAG_EN
         check($sformatf("vec%0d.wrap", i), int'(wrap), int'(vecs[i].w));
`endif
      end

      // Mid-run reset from 0x1234, with up_down high during reset.
      tick(0, 0);
      for (int i = 0; i < 16'h1234; i++) tick(1, 0);
      check("reach1234", int'(count_out), 16'h1234);
      for (int i = 0; i < 3; i++) begin
         tick(0, 1);
         check($sformatf("midrst%0d.count", i), int'(count_out), 0);
         check($sformatf("midrst%0d.up", i), int'(up_count), 0);
      end
      tick(1, 0);
      check("release_up", int'(count_out), 1);
      check_model("release_up_model");

      tick(0, 0);
      tick(1, 1);
      check("release_down", int'(count_out), 16'hFFFF);
      check("release_down.up", int'(up_count), 1);
      check_model("release_down_model");

      // Random direction and occasional reset, started near the bottom so wraps occur.
      tick(0, 0);
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(0, 39) != 0), $urandom_range(0, 1));
         check_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/up_down_count.md
# up_down_count

Free-running 16-bit up/down counter with a registered direction indicator. It advances by one on every clock edge out of reset; a single direction input selects increment or decrement. It is a leaf utility block for timing, sequencing and test stimulus. It has no enable and no load, and it wraps modulo 2^WIDTH in both directions.

## Interface
Parameters:
- WIDTH, default 16: counter width in bits.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous and active-low.
- up_down, input, 1: direction select; 0 = count up (+1), 1 = count down (−1).
- count_out, output, WIDTH: current counter value, registered.
- up_count, output, 1: registered copy of up_down; reflects the direction applied at the most recent edge.
- wrap, output, 1: present only when COUNT_WRAP_FLAG_EN is defined; see Configuration.

## Operation
- Reset: on a rising edge of clk with rst == 0:
  - count_out ← 0
  - up_count ← 0
  - wrap ← 0 (if present)
  - reset takes priority over counting.
- Normal operation: on a rising edge with rst == 1:
  - if up_down == 0: count_out ← count_out + 1
  - if up_down == 1: count_out ← count_out − 1
  - up_count ← up_down
- Arithmetic is unsigned modulo 2^WIDTH:
  - up from all-ones (16'hFFFF) gives 0.
  - down from 0 gives all-ones (16'hFFFF).
  - No saturation, no overflow output beyond the optional wrap.
- Direction change takes effect at the first edge that samples the new up_down level, with no dead cycle.
  - Example: up_down toggles 0→1 at count 12; the next edge yields 11.
- up_down is assumed stable around the sampling edge. It is not synchronised internally.

## Timing
- Latency: one cycle from up_down sample to both count_out step and up_count update. Both outputs change on the same edge.
- Outputs are pure flops with no combinational paths from inputs to outputs.
- Reset is asserted mid-count: the value is forced to 0 at the first edge with rst low, then held at 0 while rst stays low.
- Release: the first edge with rst high produces 1 when counting up, or 16'hFFFF when counting down.
- Between edges, all outputs hold their value.

## Configuration
- COUNT_WRAP_FLAG_EN defined:
  - adds output wrap, a registered one-cycle pulse.
  - wrap = 1 for the cycle following an edge where count_out stepped all-ones→0 (up) or 0→all-ones (down); 0 otherwise.
  - wrap = 0 after reset.
- COUNT_WRAP_FLAG_EN undefined:
  - port wrap and its logic are absent.
  - all other behaviour is identical.

## Structure
- Shared package count_pkg holds:
  - localparam COUNT_WIDTH_DEFAULT = 16
  - enum dir_e {DIR_UP = 1'b0, DIR_DOWN = 1'b1}, used to decode up_down.
- One natural sub-module, count_step: combinational next-value generator.
  - Inputs: current value and direction.
  - Outputs: next value and wrap-detect.
  - The top level holds the registers and the reset.

## Test plan
- Reset: rst low for one edge, then high; two edges later → count_out == 2, up_count == 0.
- Count up: continue with up_down = 0 for 10 more edges → count_out == 12, up_count == 0.
- Direction change: set up_down = 1 between edges; after 8 edges → count_out == 4, up_count == 1.
- Down wrap: continue 5 more edges → count_out == 16'hFFFF, up_count == 1. With COUNT_WRAP_FLAG_EN, wrap pulses exactly once, at the 0→FFFF step.
- Up wrap: from 16'hFFFE count up 3 edges → FFFF, 0, 1. With COUNT_WRAP_FLAG_EN, wrap is high for exactly one cycle.
- Mid-run reset: at count 0x1234, pull rst low for 3 edges → count_out == 0 and up_count == 0 after the first low edge, and both hold. After release → 1.
